scoreboard: RTL and testbench
=============================

# scoreboard

Match scorekeeper for the tug-of-war game, directly downstream of the round-victory detector. It consumes the detector's one-cycle `leftWon`/`rightWon` pulses and counts round wins per player. When either player reaches `WIN_TARGET` it latches a match winner and freezes play. Both scores and the match winner are driven to active-low seven-segment displays.

## Interface
Parameters:
- `WIN_TARGET`, default 7: round wins needed to take the match; legal range 1..9 (single decimal digit).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `Reset`  in  1  synchronous, active-high; clears all state.
- `leftWon`  in  1  one-cycle pulse: left player won a round.
- `rightWon`  in  1  one-cycle pulse: right player won a round.
- `newMatch`  in  1  synchronous, active-high; clears scores and returns to play without a full Reset.
- `leftScore`  out  4  left round-win count, 0..`WIN_TARGET`.
- `rightScore`  out  4  right round-win count, 0..`WIN_TARGET`.
- `matchOver`  out  1  high while a match winner is latched; the playfield uses it to hold off play.
- `leftMatch`  out  1  high when left won the match.
- `rightMatch`  out  1  high when right won the match.
- `leftHex`  out  7  active-low segments {g,f,e,d,c,b,a}, showing `leftScore` as a decimal digit.
- `rightHex`  out  7  same encoding, showing `rightScore`.
- `winHex`  out  7  blank in play, 'L' after a left match win, 'r' after a right match win.

## Operation
- FSM states:
  - PLAY: counting.
  - LEFT_MATCH: left won the match; terminal until cleared.
  - RIGHT_MATCH: right won the match; terminal until cleared.
- Reset values: state PLAY, both scores 0, `matchOver`/`leftMatch`/`rightMatch` 0, `leftHex`=`rightHex`=7'b1000000 ('0'), `winHex`=7'b1111111 (blank).
- Priority per cycle: `Reset` > `newMatch` > win pulses.
- `newMatch` forces state PLAY and both scores to 0. A win pulse in the same cycle is dropped.
- PLAY behaviour:
  - `leftWon & ~rightWon`: `leftScore` += 1. If the new value equals `WIN_TARGET`, next state is LEFT_MATCH.
  - `rightWon & ~leftWon`: symmetric; reaching `WIN_TARGET` goes to RIGHT_MATCH.
  - Both high: illegal from upstream; neither score changes.
  - Neither high: hold.
- In LEFT_MATCH/RIGHT_MATCH, all win pulses are ignored and scores hold.
- Scores never exceed `WIN_TARGET`, so no wrap-around is possible. The 4-bit counters saturate by construction of the FSM.
- A pulse held high for k consecutive cycles counts k times (each high cycle is a win). The upstream detector never produces adjacent pulses.
- Output decode:
  - `matchOver` = state != PLAY; `leftMatch` = LEFT_MATCH; `rightMatch` = RIGHT_MATCH.
  - Digit encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Letter encodings: 'L'=1000111, 'r'=0101111.

## Timing
- Scores and state are registered on the `posedge clk` that samples the pulse. Outputs are combinational from the registers, so they change one cycle after the pulse is presented.
- The final increment and the match latch occur on the same edge: `matchOver` rises in the same cycle that the score reaches `WIN_TARGET`.
- `Reset` or `newMatch` asserted mid-match or mid-count clears everything on the next edge. Outputs show reset values the following cycle.
- No internal pipeline. Latency from any input to any output is exactly 1 cycle.

## Structure
- `scoreboard_pkg` contains:
  - state enum `sb_state_t` {PLAY, LEFT_MATCH, RIGHT_MATCH};
  - constants `SEG_BLANK`, `SEG_L`, `SEG_R`;
  - the digit-to-segment function/table.
- Sub-module `seg7`: a 4-bit to 7-bit active-low decoder. Inputs 10–15 produce blank. It is instantiated twice, for `leftHex` and `rightHex`.
- `winHex` is a 3-way mux on state using the package constants.
- Expected size: ~150–250 lines including `seg7`.

## Test plan
- Reset held 4 cycles, then released with no pulses -> scores 0/0, `leftHex`=`rightHex`=1000000, `winHex`=1111111, `matchOver`=0.
- Three isolated `leftWon` pulses and two `rightWon` pulses -> `leftScore`=3, `rightScore`=2, `leftHex`=0110000, `rightHex`=0100100; each change is visible 1 cycle after its pulse.
- `WIN_TARGET`=7 with 7 `leftWon` pulses -> on the 7th edge `leftScore`=7, `leftMatch`=`matchOver`=1, `winHex`=1000111. Further `leftWon`/`rightWon` pulses leave the scores at 7/x.
- `leftWon` and `rightWon` high together in PLAY at scores 2/2 -> scores stay 2/2, state stays PLAY.
- In RIGHT_MATCH, `newMatch` asserted together with a `rightWon` pulse -> next cycle scores 0/0, `matchOver`=0, `winHex` blank; the pulse is not counted.
- `Reset` asserted mid-match at scores 4/6 -> next cycle all outputs are at reset values. `WIN_TARGET`=1 build: a single `rightWon` -> `rightScore`=1, `rightMatch`=1, `winHex`=0101111.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared types and segment constants for the tug-of-war match scoreboard.
//   sb_state_t   : match FSM state (PLAY, LEFT_MATCH, RIGHT_MATCH)
//   SEG_*        : active-low {g,f,e,d,c,b,a} patterns for the winner display
//   digit_to_seg : 4-bit value to active-low decimal digit, blank for 10..15
package scoreboard_pkg;

   typedef enum logic [1:0] {
      PLAY        = 2'd0,
      LEFT_MATCH  = 2'd1,
      RIGHT_MATCH = 2'd2
   } sb_state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_R     = 7'b0101111;

   function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
      logic [6:0] seg;
      unique case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/scoreboard_seg7.sv
// seg7: combinational 4-bit to active-low seven-segment decoder.
//   digit_i : value to show (0..9 decoded, 10..15 blank)
//   seg_o   : segments {g,f,e,d,c,b,a}, active low
module seg7
   import scoreboard_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = digit_to_seg(digit_i);
   end

endmodule

// File: rtl/scoreboard.sv
// scoreboard: counts round wins per player and latches the match winner.
//   clk        : system clock
//   Reset      : synchronous active-high reset, clears everything
//   leftWon    : one-cycle pulse, left player won a round
//   rightWon   : one-cycle pulse, right player won a round
//   newMatch   : synchronous clear of scores and winner, back to play
//   leftScore  : left round wins, 0..WIN_TARGET
//   rightScore : right round wins, 0..WIN_TARGET
//   matchOver  : a match winner is latched
//   leftMatch  : left won the match
//   rightMatch : right won the match
//   leftHex    : active-low digit for leftScore
//   rightHex   : active-low digit for rightScore
//   winHex     : blank in play, 'L' or 'r' once the match is decided
module scoreboard
   import scoreboard_pkg::*;
#(
   parameter int unsigned WIN_TARGET = 7
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       leftWon,
   input  logic       rightWon,
   input  logic       newMatch,
   output logic [3:0] leftScore,
   output logic [3:0] rightScore,
   output logic       matchOver,
   output logic       leftMatch,
   output logic       rightMatch,
   output logic [6:0] leftHex,
   output logic [6:0] rightHex,
   output logic [6:0] winHex
);

   localparam logic [3:0] Target = 4'(WIN_TARGET);

   sb_state_t  state_q, state_d;
   logic [3:0] left_score_q, left_score_d;
   logic [3:0] right_score_q, right_score_d;

   // Scores stop at Target because reaching it leaves PLAY, and only PLAY counts.
   always_comb begin
      state_d       = state_q;
      left_score_d  = left_score_q;
      right_score_d = right_score_q;

      if (newMatch) begin
         state_d       = PLAY;
         left_score_d  = 4'd0;
         right_score_d = 4'd0;
      end else if (state_q == PLAY) begin
         if (leftWon && !rightWon) begin
            left_score_d = left_score_q + 4'd1;
            if (left_score_d == Target) begin
               state_d = LEFT_MATCH;
            end
         end else if (rightWon && !leftWon) begin
            right_score_d = right_score_q + 4'd1;
            if (right_score_d == Target) begin
               state_d = RIGHT_MATCH;
            end
         end
         // Both pulses together is an upstream fault: hold.
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q       <= PLAY;
         left_score_q  <= 4'd0;
         right_score_q <= 4'd0;
      end else begin
         state_q       <= state_d;
         left_score_q  <= left_score_d;
         right_score_q <= right_score_d;
      end
   end

   always_comb begin
      leftScore  = left_score_q;
      rightScore = right_score_q;
      matchOver  = (state_q != PLAY);
      leftMatch  = (state_q == LEFT_MATCH);
      rightMatch = (state_q == RIGHT_MATCH);
      unique case (state_q)
         LEFT_MATCH:  winHex = SEG_L;
         RIGHT_MATCH: winHex = SEG_R;
         default:     winHex = SEG_BLANK;
      endcase
   end

   seg7 u_left_seg (
      .digit_i (left_score_q),
      .seg_o   (leftHex)
   );

   seg7 u_right_seg (
      .digit_i (right_score_q),
      .seg_o   (rightHex)
   );

endmodule

// File: tb/tb_scoreboard.sv
// Directed self-checking bench for scoreboard: default WIN_TARGET=7 instance plus
// a WIN_TARGET=1 instance sharing clock, Reset and newMatch.
module tb_scoreboard;

   logic clk = 1'b0;
   logic Reset = 1'b1;
   logic newMatch = 1'b0;
   logic leftWon = 1'b0;
   logic rightWon = 1'b0;
   logic left1 = 1'b0;
   logic right1 = 1'b0;

   logic [3:0] leftScore, rightScore;
   logic       matchOver, leftMatch, rightMatch;
   logic [6:0] leftHex, rightHex, winHex;

   logic [3:0] leftScore1, rightScore1;
   logic       matchOver1, leftMatch1, rightMatch1;
   logic [6:0] leftHex1, rightHex1, winHex1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   scoreboard dut (
      .clk        (clk),
      .Reset      (Reset),
      .leftWon    (leftWon),
      .rightWon   (rightWon),
      .newMatch   (newMatch),
      .leftScore  (leftScore),
      .rightScore (rightScore),
      .matchOver  (matchOver),
      .leftMatch  (leftMatch),
      .rightMatch (rightMatch),
      .leftHex    (leftHex),
      .rightHex   (rightHex),
      .winHex     (winHex)
   );

   scoreboard #(.WIN_TARGET(1)) dut1 (
      .clk        (clk),
      .Reset      (Reset),
      .leftWon    (left1),
      .rightWon   (right1),
      .newMatch   (newMatch),
      .leftScore  (leftScore1),
      .rightScore (rightScore1),
      .matchOver  (matchOver1),
      .leftMatch  (leftMatch1),
      .rightMatch (rightMatch1),
      .leftHex    (leftHex1),
      .rightHex   (rightHex1),
      .winHex     (winHex1)
   );

   // Present one cycle of win inputs, then return at the following negedge
   // (the sampling edge has passed), followed by one idle cycle.
   task automatic pulse(input logic l, input logic r);
      @(negedge clk);
      leftWon  = l;
      rightWon = r;
      @(negedge clk);
      leftWon  = 1'b0;
      rightWon = 1'b0;
      @(negedge clk);
   endtask

   task automatic clear_match();
      @(negedge clk);
      newMatch = 1'b1;
      @(negedge clk);
      newMatch = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (4) @(negedge clk);
      Reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({leftScore, rightScore} !== 8'h00) begin
         failures++;
         $display("FAIL reset_scores: got %h expected 00", {leftScore, rightScore});
      end
      checks++;
      if ({leftHex, rightHex} !== {7'b1000000, 7'b1000000}) begin
         failures++;
         $display("FAIL reset_hex: got %b %b expected 1000000 1000000", leftHex, rightHex);
      end
      checks++;
      if (winHex !== 7'b1111111) begin
         failures++;
         $display("FAIL reset_winhex: got %b expected 1111111", winHex);
      end
      checks++;
      if ({matchOver, leftMatch, rightMatch} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 000", {matchOver, leftMatch, rightMatch});
      end
      checks++;
      if ({leftScore1, rightScore1, matchOver1, winHex1} !== {8'h00, 1'b0, 7'b1111111}) begin
         failures++;
         $display("FAIL reset_dut1: got %h %b %b expected 00 0 1111111",
                  {leftScore1, rightScore1}, matchOver1, winHex1);
      end
   endtask

   task automatic test_count();
      // First pulse checked for latency: no change before the edge, change after.
      @(negedge clk);
      leftWon = 1'b1;
      #1;
      checks++;
      if (leftScore !== 4'd0) begin
         failures++;
         $display("FAIL count_before_edge: got %0d expected 0", leftScore);
      end
      @(negedge clk);
      leftWon = 1'b0;
      checks++;
      if (leftScore !== 4'd1 || leftHex !== 7'b1111001) begin
         failures++;
         $display("FAIL count_first: got %0d/%b expected 1/1111001", leftScore, leftHex);
      end
      pulse(1'b0, 1'b1);
      checks++;
      if ({leftScore, rightScore} !== {4'd1, 4'd1}) begin
         failures++;
         $display("FAIL count_right1: got %0d/%0d expected 1/1", leftScore, rightScore);
      end
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      checks++;
      if ({leftScore, rightScore} !== {4'd3, 4'd2}) begin
         failures++;
         $display("FAIL count_scores: got %0d/%0d expected 3/2", leftScore, rightScore);
      end
      checks++;
      if ({leftHex, rightHex} !== {7'b0110000, 7'b0100100}) begin
         failures++;
         $display("FAIL count_hex: got %b %b expected 0110000 0100100", leftHex, rightHex);
      end
      checks++;
      if (matchOver !== 1'b0 || winHex !== 7'b1111111) begin
         failures++;
         $display("FAIL count_play: got %b %b expected 0 1111111", matchOver, winHex);
      end
   endtask

   task automatic test_both_high();
      clear_match();
      repeat (2) pulse(1'b1, 1'b0);
      repeat (2) pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b1);
      checks++;
      if ({leftScore, rightScore} !== {4'd2, 4'd2}) begin
         failures++;
         $display("FAIL both_scores: got %0d/%0d expected 2/2", leftScore, rightScore);
      end
      checks++;
      if (matchOver !== 1'b0) begin
         failures++;
         $display("FAIL both_state: got matchOver=%b expected 0", matchOver);
      end
   endtask

   task automatic test_left_match();
      clear_match();
      repeat (6) pulse(1'b1, 1'b0);
      checks++;
      if (leftScore !== 4'd6 || matchOver !== 1'b0) begin
         failures++;
         $display("FAIL lmatch_six: got %0d/%b expected 6/0", leftScore, matchOver);
      end
      pulse(1'b1, 1'b0);
      checks++;
      if (leftScore !== 4'd7 || leftHex !== 7'b1111000) begin
         failures++;
         $display("FAIL lmatch_score: got %0d/%b expected 7/1111000", leftScore, leftHex);
      end
      checks++;
      if ({matchOver, leftMatch, rightMatch} !== 3'b110 || winHex !== 7'b1000111) begin
         failures++;
         $display("FAIL lmatch_flags: got %b %b expected 110 1000111",
                  {matchOver, leftMatch, rightMatch}, winHex);
      end
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      checks++;
      if ({leftScore, rightScore} !== {4'd7, 4'd0} || leftMatch !== 1'b1) begin
         failures++;
         $display("FAIL lmatch_frozen: got %0d/%0d lm=%b expected 7/0 lm=1",
                  leftScore, rightScore, leftMatch);
      end
   endtask

   task automatic test_new_match_priority();
      clear_match();
      repeat (7) pulse(1'b0, 1'b1);
      checks++;
      if ({matchOver, leftMatch, rightMatch} !== 3'b101 || winHex !== 7'b0101111) begin
         failures++;
         $display("FAIL rmatch_flags: got %b %b expected 101 0101111",
                  {matchOver, leftMatch, rightMatch}, winHex);
      end
      @(negedge clk);
      newMatch = 1'b1;
      rightWon = 1'b1;
      @(negedge clk);
      newMatch = 1'b0;
      rightWon = 1'b0;
      checks++;
      if ({leftScore, rightScore} !== 8'h00) begin
         failures++;
         $display("FAIL newmatch_scores: got %0d/%0d expected 0/0", leftScore, rightScore);
      end
      checks++;
      if (matchOver !== 1'b0 || winHex !== 7'b1111111) begin
         failures++;
         $display("FAIL newmatch_state: got %b %b expected 0 1111111", matchOver, winHex);
      end
   endtask

   task automatic test_reset_mid();
      clear_match();
      repeat (4) pulse(1'b1, 1'b0);
      repeat (6) pulse(1'b0, 1'b1);
      checks++;
      if ({leftHex, rightHex} !== {7'b0011001, 7'b0000010}) begin
         failures++;
         $display("FAIL mid_hex: got %b %b expected 0011001 0000010", leftHex, rightHex);
      end
      @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      checks++;
      if ({leftScore, rightScore, matchOver, leftMatch, rightMatch} !== 11'd0) begin
         failures++;
         $display("FAIL mid_reset_regs: got %0d/%0d %b expected 0/0 000", leftScore,
                  rightScore, {matchOver, leftMatch, rightMatch});
      end
      checks++;
      if ({leftHex, rightHex, winHex} !== {7'b1000000, 7'b1000000, 7'b1111111}) begin
         failures++;
         $display("FAIL mid_reset_hex: got %b %b %b expected 1000000 1000000 1111111",
                  leftHex, rightHex, winHex);
      end
   endtask

   task automatic test_target_one();
      @(negedge clk);
      right1 = 1'b1;
      @(negedge clk);
      right1 = 1'b0;
      checks++;
      if (rightScore1 !== 4'd1 || rightHex1 !== 7'b1111001) begin
         failures++;
         $display("FAIL t1_score: got %0d/%b expected 1/1111001", rightScore1, rightHex1);
      end
      checks++;
      if ({matchOver1, leftMatch1, rightMatch1} !== 3'b101 || winHex1 !== 7'b0101111) begin
         failures++;
         $display("FAIL t1_flags: got %b %b expected 101 0101111",
                  {matchOver1, leftMatch1, rightMatch1}, winHex1);
      end
      @(negedge clk);
      left1 = 1'b1;
      @(negedge clk);
      left1 = 1'b0;
      checks++;
      if ({leftScore1, rightScore1} !== {4'd0, 4'd1} || leftMatch1 !== 1'b0) begin
         failures++;
         $display("FAIL t1_frozen: got %0d/%0d lm=%b expected 0/1 lm=0",
                  leftScore1, rightScore1, leftMatch1);
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_both_high();
      test_left_match();
      test_new_match_priority();
      test_reset_mid();
      test_target_one();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
